cla_addsub_pipe: RTL and testbench
==================================

// Module: cla_addsub_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the MIPS_Archi ALU datapath; successor to the fixed 8-bit CLA.
//  Carry chain is cut into STAGES register-separated segments of BLOCK-bit lookahead groups.
//  Valid/ready handshake on both sides with per-stage bubble collapse.
//  Add/sub mode and carry/borrow, signed-overflow and zero flags travel with each result.
// PARAMETERS
//  WIDTH   32  operand/result width; multiple of BLOCK
//  BLOCK   4   bits per lookahead group (generate/propagate computed per group)
//  STAGES  2   pipeline stages = latency in cycles; 1..WIDTH/BLOCK, must divide WIDTH/BLOCK
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  op         in   1      0 = add, 1 = subtract
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  S          out  WIDTH  sum/difference, modulo 2^WIDTH
//  Cout       out  1      carry-out (add) / borrow-out (sub)
//  Ovf        out  1      two's-complement signed overflow
//  Zero       out  1      S == 0
// BEHAVIOUR
//  - Add:  {Cout,S} = A + B + Cin.
//  - Sub:  S = A - B - Cin, computed as A + ~B + ~Cin; Cout = ~(raw carry), i.e. 1 = borrow.
//  - Ovf = carry into MSB XOR raw carry out of MSB, for both ops; Zero = ~|S.
//  - Segment k (0 = LSB) resolves bits [k*W/STAGES +: W/STAGES] in stage k.
//    Its carry-in is the registered carry from stage k-1 (stage 0: Cin, inverted when op=1).
//    Upper operand bits and already-resolved lower sum bits ride along in stage registers.
//  - Latency: a beat accepted in cycle t presents out_valid in cycle t+STAGES when no stall occurs.
//  - Throughput: one beat per cycle when out_ready is held high.
//  - Handshake: transfer on valid&&ready on each side.
//    Stage i loads when it is empty or stage i+1 loads (last stage: when out_ready); in_ready = stage-0 load condition.
//    Combinational path out_ready -> in_ready is permitted.
//  - Upstream must hold A/B/op/Cin stable while in_valid && !in_ready.
//    Outputs hold stable while out_valid && !out_ready.
//  - Bubbles collapse: an empty stage loads even when later stages are stalled.
//  - Simultaneous accept and emit with a full pipe: both occur; no beat is lost or duplicated.
//  - Reset (async assert, sync deassert externally): all stage valid bits cleared.
//    out_valid=0, S=0, Cout=0, Ovf=0, Zero=0. in_ready=1 from the first cycle after reset.
//    Mid-operation reset discards all in-flight beats.
//  - Data registers of empty stages do not toggle (stage enable = load condition).
// TESTING
//  (defaults WIDTH=8 BLOCK=4 STAGES=2 unless stated; out_ready=1 unless stated)
//  1 add A=a5 B=5a Cin=0 -> 2 cycles later S=ff Cout=0 Ovf=0 Zero=0
//  2 add A=f1 B=1f Cin=1 -> S=11 Cout=1; add e2+2e Cin=0 -> S=10 Cout=1; back-to-back, one result per cycle
//  3 sub 10-01 Cin=0 -> S=0f Cout=0; sub 01-02 -> S=ff Cout=1; sub 13-13 -> S=00 Zero=1
//  4 add 7f+01 -> S=80 Ovf=1; sub 80-01 -> S=7f Ovf=1 Cout=0
//  5 stream 4 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 beats held; S stable; order preserved
//  6 reset with 2 beats in flight -> out_valid=0 same cycle, all flags 0; rerun 1 at WIDTH=32 STAGES=4 vs reference model, 10k random

Source files
------------

// File: rtl/cla_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe_if
//   Bundles the operand-side and result-side valid/ready handshakes of the
//   pipelined carry-lookahead adder/subtractor.
//
//   Operand side : in_valid, in_ready, op (0 add / 1 sub), A, B, Cin
//   Result side  : out_valid, out_ready, S, Cout (carry / borrow), Ovf, Zero
//
//   master : upstream/downstream environment (drives operands and out_ready)
//   slave  : the adder/subtractor itself
// ---------------------------------------------------------------------------
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             Zero;

    modport master (
        output in_valid, op, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, Zero
    );

    modport slave (
        input  in_valid, op, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, Zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor for the ALU datapath.
//   The WIDTH-bit carry chain is cut into STAGES segments of WIDTH/STAGES
//   bits; each segment is built from BLOCK-bit lookahead groups and is
//   resolved in its own pipeline stage. The carry between segments is
//   registered, so the result appears STAGES cycles after acceptance.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears every stage valid bit)
//   bus    : slave modport of cla_addsub_pipe_if
//            in_valid/in_ready  operand handshake, op 0=add 1=sub, A, B, Cin
//            out_valid/out_ready result handshake, S, Cout, Ovf, Zero
//
// Arithmetic
//   add : {Cout,S} = A + B + Cin
//   sub : S = A + ~B + ~Cin, Cout = ~raw carry (1 = borrow)
//   Ovf = carry into MSB ^ raw carry out of MSB, Zero = ~|S
//
// Flow control
//   Stage k loads when it is empty or stage k+1 loads; the last stage loads
//   when it is empty or out_ready is high. in_ready is the stage-0 load
//   condition, so out_ready reaches in_ready combinationally and empty
//   stages fill even while later stages are stalled.
// ---------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    cla_addsub_pipe_if.slave    bus
);

    localparam int SEG  = WIDTH / STAGES;   // bits resolved per stage
    localparam int NGRP = SEG / BLOCK;      // lookahead groups per stage

    // Lookahead sum of one segment. Inside a group every bit carry is the
    // flattened generate/propagate expression of the group carry-in; the
    // group carry-out uses group G/P so groups chain without bit ripple.
    // Returns {carry out of segment, segment sum}.
    function automatic logic [SEG:0] cla_seg(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           cg;
        logic           gg;
        logic           pg;
        logic           t;
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        cg = cin;
        for (int grp = 0; grp < NGRP; grp++) begin
            for (int i = 0; i < BLOCK; i++) begin
                t = cg;
                for (int j = 0; j < i; j++) t = t & p[grp*BLOCK + j];
                c[grp*BLOCK + i] = t;
                for (int j = 0; j < i; j++) begin
                    t = g[grp*BLOCK + j];
                    for (int m = j + 1; m < i; m++) t = t & p[grp*BLOCK + m];
                    c[grp*BLOCK + i] = c[grp*BLOCK + i] | t;
                end
            end
            gg = 1'b0;
            pg = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                t = g[grp*BLOCK + j];
                for (int m = j + 1; m < BLOCK; m++) t = t & p[grp*BLOCK + m];
                gg = gg | t;
                pg = pg & p[grp*BLOCK + j];
            end
            cg = gg | (pg & cg);
            c[(grp + 1)*BLOCK] = cg;
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    // ld[k] : stage k captures its source this cycle; ld[STAGES] is the sink
    logic ld [STAGES+1];

    assign ld[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // operand bits still unresolved when entering stage k
        localparam int REM = WIDTH - k*SEG;

        logic                  src_vld;
        logic [REM-1:0]        src_a;
        logic [REM-1:0]        src_b;    // already inverted for subtract
        logic                  src_c;    // raw carry into this segment
        logic                  src_op;
        logic [SEG:0]          seg_r;
        logic [(k+1)*SEG-1:0]  s_nxt;

        logic                  vld_p;
        logic [(k+1)*SEG-1:0]  s_p;      // resolved low sum bits so far
        logic                  c_p;      // raw carry out of this segment
        logic                  op_p;

        // ---- stage k input: operands from the bus or from stage k-1 ----
        if (k == 0) begin : g_head
            assign src_vld = bus.in_valid;
            assign src_a   = bus.A;
            assign src_b   = bus.B ^ {WIDTH{bus.op}};
            assign src_c   = bus.Cin ^ bus.op;
            assign src_op  = bus.op;
            assign s_nxt   = seg_r[SEG-1:0];
        end else begin : g_body
            assign src_vld = g_stg[k-1].vld_p;
            assign src_a   = g_stg[k-1].g_fwd.a_p;
            assign src_b   = g_stg[k-1].g_fwd.b_p;
            assign src_c   = g_stg[k-1].c_p;
            assign src_op  = g_stg[k-1].op_p;
            assign s_nxt   = {seg_r[SEG-1:0], g_stg[k-1].s_p};
        end

        assign ld[k] = !vld_p || ld[k+1];
        assign seg_r = cla_seg(src_a[SEG-1:0], src_b[SEG-1:0], src_c);

        // ---- stage k register ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
            end else if (ld[k]) begin
                vld_p <= src_vld;
            end
        end

        // Data captures only a real beat, so empty stages stay quiet.
        always_ff @(posedge clk) begin
            if (ld[k] && src_vld) begin
                s_p  <= s_nxt;
                c_p  <= seg_r[SEG];
                op_p <= src_op;
            end
        end

        if (k < STAGES-1) begin : g_fwd
            logic [REM-SEG-1:0] a_p;
            logic [REM-SEG-1:0] b_p;

            always_ff @(posedge clk) begin
                if (ld[k] && src_vld) begin
                    a_p <= src_a[REM-1:SEG];
                    b_p <= src_b[REM-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_p;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk) begin
                if (ld[k] && src_vld) begin
                    ovf_p <= seg_r[SEG] ^ seg_r[SEG-1] ^ src_a[SEG-1] ^ src_b[SEG-1];
                end
            end
        end
    end

    // ---- output: last stage, masked to zero while empty ----
    logic last_vld;

    assign last_vld      = g_stg[STAGES-1].vld_p;
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = last_vld;
    assign bus.S         = last_vld ? g_stg[STAGES-1].s_p : '0;
    assign bus.Cout      = last_vld & (g_stg[STAGES-1].c_p ^ g_stg[STAGES-1].op_p);
    assign bus.Ovf       = last_vld & g_stg[STAGES-1].g_tail.ovf_p;
    assign bus.Zero      = last_vld & ~|g_stg[STAGES-1].s_p;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Directed checks on an 8-bit, 2-stage instance (hand-computed results,
//   latency, throughput, stall, reset flush) followed by 10k random beats
//   on a 32-bit, 4-stage instance against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_addsub_pipe_if #(.WIDTH(8))  b8 ();
    cla_addsub_pipe_if #(.WIDTH(32)) b32 ();

    cla_addsub_pipe #(.WIDTH(8), .BLOCK(4), .STAGES(2)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- 8-bit result capture: {S, Cout, Ovf, Zero} and capture cycle ----
    logic [10:0] r8_q[$];
    int          c8_q[$];

    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            r8_q.push_back({b8.S, b8.Cout, b8.Ovf, b8.Zero});
            c8_q.push_back(cyc);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send8(input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output int acc);
        int n;
        n = 0;
        b8.in_valid = 1'b1;
        b8.op = op;
        b8.A = a;
        b8.B = b;
        b8.Cin = cin;
        @(negedge clk);
        while (!b8.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send8_rdy", b8.in_ready, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic expect8(input string tag, input logic [7:0] s, input logic c,
                           input logic o, input logic z, output int oc);
        int n;
        logic [10:0] r;
        n = 0;
        oc = 0;
        while (r8_q.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_avail"}, r8_q.size() > 0, 1);
        if (r8_q.size() > 0) begin
            r = r8_q.pop_front();
            oc = c8_q.pop_front();
            chk({tag, "_S"}, r[10:3], s);
            chk({tag, "_Cout"}, r[2], c);
            chk({tag, "_Ovf"}, r[1], o);
            chk({tag, "_Zero"}, r[0], z);
        end
    endtask

    // ---- 32-bit reference model and scoreboard ----
    function automatic logic [34:0] ref32(input logic o, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] r;
        longint      sr;
        logic        ov;
        if (!o) begin
            r  = {1'b0, a} + {1'b0, b} + {32'b0, c};
            sr = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end else begin
            r  = {1'b0, a} - {1'b0, b} - {32'b0, c};
            sr = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        end
        ov = (sr[63:31] != {33{sr[31]}});
        return {r[31:0], r[32], ov, (r[31:0] == 32'd0)};
    endfunction

    logic [34:0] e32_q[$];
    logic        drv32_done = 1'b0;

    always @(negedge clk) begin
        if (b32.out_valid && b32.out_ready) begin
            if (e32_q.size() == 0) chk("r32_spurious", e32_q.size(), 1);
            else chk("r32", {b32.S, b32.Cout, b32.Ovf, b32.Zero}, e32_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int acc1, acc2, oc1, oc2, dmy, dmy2;

    initial begin
        b8.in_valid = 0; b8.op = 0; b8.A = 0; b8.B = 0; b8.Cin = 0; b8.out_ready = 1;
        b32.in_valid = 0; b32.op = 0; b32.A = 0; b32.B = 0; b32.Cin = 0; b32.out_ready = 1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", b8.out_valid, 0);
        chk("rst_S", b8.S, 0);
        chk("rst_flags", {b8.Cout, b8.Ovf, b8.Zero}, 0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inrdy", b8.in_ready, 1);

        // 1: single add, latency 2
        sync();
        send8(0, 8'ha5, 8'h5a, 0, acc1);
        expect8("t1", 8'hff, 0, 0, 0, oc1);
        chk("t1_lat", oc1 - acc1, 2);

        // 2: back-to-back adds with carry-out
        sync();
        send8(0, 8'hf1, 8'h1f, 1, acc1);
        send8(0, 8'he2, 8'h2e, 0, acc2);
        chk("t2_accgap", acc2 - acc1, 1);
        expect8("t2a", 8'h11, 1, 0, 0, oc1);
        expect8("t2b", 8'h10, 1, 0, 0, oc2);
        chk("t2_outgap", oc2 - oc1, 1);

        // 3: subtracts, borrow and zero
        sync();
        send8(1, 8'h10, 8'h01, 0, dmy);
        send8(1, 8'h01, 8'h02, 0, dmy);
        send8(1, 8'h13, 8'h13, 0, dmy);
        expect8("t3a", 8'h0f, 0, 0, 0, oc1);
        expect8("t3b", 8'hff, 1, 0, 0, oc1);
        expect8("t3c", 8'h00, 0, 0, 1, oc1);

        // 4: signed overflow
        sync();
        send8(0, 8'h7f, 8'h01, 0, dmy);
        send8(1, 8'h80, 8'h01, 0, dmy);
        expect8("t4a", 8'h80, 0, 1, 0, oc1);
        expect8("t4b", 8'h7f, 0, 1, 0, oc1);

        // 5: 4-beat stream with 3-cycle output stall
        sync();
        b8.out_ready = 1'b0;
        fork
            begin
                send8(0, 8'h01, 8'h02, 0, dmy);
                send8(0, 8'h10, 8'h20, 0, dmy);
                send8(1, 8'h05, 8'h03, 0, dmy);
                send8(0, 8'hff, 8'h01, 0, dmy);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("t5_inrdy_lo", b8.in_ready, 0);
                chk("t5_vld", b8.out_valid, 1);
                chk("t5_S_held", b8.S, 8'h03);
                sync();
                chk("t5_S_stable", b8.S, 8'h03);
                chk("t5_inrdy_still", b8.in_ready, 0);
                b8.out_ready = 1'b1;
            end
        join
        expect8("t5a", 8'h03, 0, 0, 0, oc1);
        expect8("t5b", 8'h30, 0, 0, 0, oc1);
        expect8("t5c", 8'h02, 0, 0, 0, oc1);
        expect8("t5d", 8'h00, 1, 0, 1, oc1);

        // 6: reset with two beats in flight
        sync();
        b8.out_ready = 1'b0;
        send8(0, 8'h80, 8'h80, 0, dmy);
        send8(0, 8'h01, 8'h01, 0, dmy2);
        @(negedge clk);
        chk("t6_full", {b8.out_valid, b8.Cout, b8.Ovf, b8.Zero}, 4'b1111);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_vld", b8.out_valid, 0);
        chk("t6_S", b8.S, 0);
        chk("t6_flags", {b8.Cout, b8.Ovf, b8.Zero}, 0);
        chk("t6_inrdy", b8.in_ready, 1);
        sync();
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        repeat (5) sync();
        chk("t6_flushed", r8_q.size(), 0);

        // 32-bit, 4-stage random run with random back-pressure
        sync();
        fork
            begin
                logic [31:0] a, b;
                logic o, c;
                int n;
                for (int i = 0; i < 10000; i++) begin
                    a = $urandom;
                    b = $urandom;
                    o = 1'($urandom_range(0, 1));
                    c = 1'($urandom_range(0, 1));
                    if (i % 8 == 0) b = a;
                    if (i % 16 == 1) a = 32'h7fffffff;
                    if (i % 16 == 2) a = 32'h80000000;
                    b32.in_valid = 1'b1;
                    b32.op = o;
                    b32.A = a;
                    b32.B = b;
                    b32.Cin = c;
                    n = 0;
                    @(negedge clk);
                    while (!b32.in_ready && n < 100) begin
                        n++;
                        @(negedge clk);
                    end
                    if (!b32.in_ready) begin
                        chk("r32_rdy_timeout", b32.in_ready, 1);
                        break;
                    end
                    e32_q.push_back(ref32(o, a, b, c));
                    sync();
                end
                b32.in_valid = 1'b0;
                drv32_done = 1'b1;
            end
            begin
                while (!drv32_done) begin
                    sync();
                    b32.out_ready = ($urandom_range(0, 3) != 0);
                end
                b32.out_ready = 1'b1;
            end
        join
        begin
            int n;
            n = 0;
            while (e32_q.size() > 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("r32_drain", e32_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
